dbg_capture_fifo: RTL and testbench
===================================

DBG_CAPTURE_FIFO -- requirements
Module: dbg_capture_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32: captured word width.
REQ-002 SHALL have parameter NCH, default 4: number of debug channels; legal values 2, 4, 8, 16; CH_W = log2(NCH).
REQ-003 SHALL have parameter DEPTH, default 8: FIFO entries; power of two, 2..256; CNT_W = log2(DEPTH)+1.
REQ-004 SHALL have parameter MODE, default 0: full policy; 0 = drop newest, 1 = overwrite oldest.
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port cap_en, input, 1: capture strobe, one capture per high cycle (asserted by the controller on CPDR in execute state).
REQ-008 SHALL have port cap_ch, input, CH_W: target channel of the capture.
REQ-009 SHALL have port cap_data, input, DATA_W: value to capture (integer-register read data).
REQ-010 SHALL have port clr, input, 1: synchronous FIFO flush.
REQ-011 SHALL have port dr, output, NCH*DATA_W: latest value per channel; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port out_valid, output, 1: FIFO head is valid.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts head.
REQ-014 SHALL have port out_data, output, DATA_W: head data.
REQ-015 SHALL have port out_ch, output, CH_W: head channel.
REQ-016 SHALL have port count, output, CNT_W: current occupancy.
REQ-017 SHALL have port ovf, output, 1: sticky flag, set when any capture was lost or overwrote an entry.
REQ-018 SHALL have port drop_cnt, output, 16: saturating count of lost or overwritten entries.

Function
REQ-019 SHALL, on cap_en=1, load dr channel cap_ch with cap_data at the next edge, regardless of FIFO state or clr.
REQ-020 SHALL, on cap_en=1 with clr=0, push {cap_ch, cap_data} into the FIFO, subject to REQ-024/025.
REQ-021 SHALL be first-word-fall-through: out_valid = (count != 0); out_data/out_ch show the head combinationally from storage.
REQ-022 SHALL pop the head on an edge where out_valid=1 and out_ready=1; out_ready while empty has no effect.
REQ-023 SHALL, on simultaneous push and pop, perform both: count unchanged, and the order is preserved; when count=DEPTH this is not an overflow.
REQ-024 SHALL, in MODE 0 with count=DEPTH and no pop in that cycle, discard the push, set ovf, and increment drop_cnt.
REQ-025 SHALL, in MODE 1 with count=DEPTH and no pop in that cycle, write the new entry, advance the read pointer past the oldest entry, keep count=DEPTH, set ovf, and increment drop_cnt.
REQ-026 SHALL wrap read and write pointers modulo DEPTH.
REQ-027 SHALL saturate drop_cnt at 16'hFFFF.
REQ-028 SHALL, on clr=1, set count=0, equalise the pointers, and clear ovf and drop_cnt; clr overrides a same-cycle push and pop; dr is unaffected.
REQ-029 SHALL keep count equal to pushes minus pops at all times, within 0..DEPTH.

Reset
REQ-030 SHALL, on reset=1 at an edge, zero every dr channel, count, ovf, drop_cnt and both pointers; out_valid=0 in the following cycle.
REQ-031 SHALL give reset priority over cap_en, clr and pop in the same cycle, including reset mid-stream with the FIFO partly full.
REQ-032 SHALL leave FIFO storage contents undefined after reset, with no output depending on them while count=0.

Verification (DEPTH=4, NCH=4, DATA_W=32)
REQ-033 Bench SHALL check: capture ch2=32'h12345678 with out_ready=0 -> dr[95:64]=32'h12345678, count=1, out_ch=2, out_data=32'h12345678.
REQ-034 Bench SHALL check: MODE 0, captures 1..5 on ch0 with out_ready=0 -> count=4, ovf=1, drop_cnt=1, pops yield 1,2,3,4, dr[31:0]=5.
REQ-035 Bench SHALL check: MODE 1, captures 1..6 -> count=4, drop_cnt=2, pops yield 3,4,5,6.
REQ-036 Bench SHALL check: FIFO full, with cap_en and out_ready=1 in the same cycle -> count stays 4, ovf=0, pops stream in order.
REQ-037 Bench SHALL check: count=3 with clr and cap_en asserted together (value 9, ch1) -> count=0, ovf=0, dr[63:32]=9.
REQ-038 Bench SHALL check: reset asserted with count=2 and cap_en high -> the next cycle shows all dr=0, count=0, out_valid=0, drop_cnt=0.

Source files
------------

// File: rtl/dbg_capture_fifo.sv
// Debug capture buffer: keeps the latest value per channel and queues every
// capture as {channel, data} in a first-word-fall-through FIFO.
module dbg_capture_fifo #(
    parameter int DATA_W = 32,
    parameter int NCH    = 4,
    parameter int DEPTH  = 8,
    parameter int MODE   = 0,
    localparam int CH_W  = $clog2(NCH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cap_en,
    input  logic [CH_W-1:0]       cap_ch,
    input  logic [DATA_W-1:0]     cap_data,
    input  logic                  clr,
    output logic [NCH*DATA_W-1:0] dr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [CH_W-1:0]       out_ch,
    output logic [CNT_W-1:0]      count,
    output logic                  ovf,
    output logic [15:0]           drop_cnt
);

    localparam int PTR_W     = $clog2(DEPTH);
    localparam bit OVERWRITE = (MODE == 1);

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [CH_W-1:0]   mem_ch   [DEPTH];
    logic [DATA_W-1:0] dr_q     [NCH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    logic full;
    logic push;
    logic pop;
    logic lost;
    logic do_write;

    // Output handshake: the head transfers on a rising edge where out_valid
    // and out_ready are both high; out_valid never depends on out_ready.
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
    assign out_ch    = out_valid ? mem_ch[rd_ptr] : '0;

    assign full     = (count == CNT_W'(DEPTH));
    assign push     = cap_en & ~clr;
    assign pop      = out_valid & out_ready & ~clr;
    // A push into a full FIFO with no pop loses either itself or the oldest entry.
    assign lost     = push & full & ~pop;
    assign do_write = push & (~lost | OVERWRITE);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (clr) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop || (lost && OVERWRITE)) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop && !full) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (lost) begin
                ovf <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

    // Storage is left unreset; nothing observes it while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_write && !reset) begin
            mem_data[wr_ptr] <= cap_data;
            mem_ch[wr_ptr]   <= cap_ch;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                dr_q[k] <= '0;
            end
        end else if (cap_en) begin
            dr_q[cap_ch] <= cap_data;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_dr
        assign dr[k*DATA_W +: DATA_W] = dr_q[k];
    end

endmodule

// File: tb/tb_dbg_capture_fifo.sv
// Self-checking bench: a drop-newest and an overwrite-oldest instance share
// stimulus; queue models predict every popped entry and the status outputs.
module tb_dbg_capture_fifo;

  localparam int DATA_W = 32;
  localparam int NCH    = 4;
  localparam int DEPTH  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cap_en;
  logic [1:0]  cap_ch;
  logic [31:0] cap_data;
  logic        clr;
  logic        out_ready;

  logic [127:0] dr0, dr1;
  logic         out_valid0, out_valid1;
  logic [31:0]  out_data0, out_data1;
  logic [1:0]   out_ch0, out_ch1;
  logic [2:0]   count0, count1;
  logic         ovf0, ovf1;
  logic [15:0]  drop0, drop1;

  dbg_capture_fifo #(.DATA_W(DATA_W), .NCH(NCH), .DEPTH(DEPTH), .MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .cap_en(cap_en), .cap_ch(cap_ch), .cap_data(cap_data),
    .clr(clr), .dr(dr0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_ch(out_ch0), .count(count0), .ovf(ovf0), .drop_cnt(drop0)
  );

  dbg_capture_fifo #(.DATA_W(DATA_W), .NCH(NCH), .DEPTH(DEPTH), .MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .cap_en(cap_en), .cap_ch(cap_ch), .cap_data(cap_data),
    .clr(clr), .dr(dr1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_ch(out_ch1), .count(count1), .ovf(ovf1), .drop_cnt(drop1)
  );

  // ---------------- scoreboard state ----------------
  logic [33:0] exp_q0[$];
  logic [33:0] exp_q1[$];
  logic        ovf_m0, ovf_m1;
  logic [15:0] drop_m0, drop_m1;
  logic [31:0] dr_m[4];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_status();
    logic [127:0] dr_exp;
    dr_exp = {dr_m[3], dr_m[2], dr_m[1], dr_m[0]};
    check("count0", 128'(count0), 128'(exp_q0.size()));
    check("count1", 128'(count1), 128'(exp_q1.size()));
    check("valid0", 128'(out_valid0), 128'(exp_q0.size() != 0));
    check("valid1", 128'(out_valid1), 128'(exp_q1.size() != 0));
    check("ovf0", 128'(ovf0), 128'(ovf_m0));
    check("ovf1", 128'(ovf1), 128'(ovf_m1));
    check("drop0", 128'(drop0), 128'(drop_m0));
    check("drop1", 128'(drop1), 128'(drop_m1));
    check("dr0", dr0, dr_exp);
    check("dr1", dr1, dr_exp);
    if (exp_q0.size() != 0) check("head0", 128'({out_ch0, out_data0}), 128'(exp_q0[0]));
    if (exp_q1.size() != 0) check("head1", 128'({out_ch1, out_data1}), 128'(exp_q1[0]));
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; drives one cycle, checks popped heads before the
  // edge, updates the models, and returns at the following posedge+1.
  task automatic step(input logic cap, input logic [1:0] ch, input logic [31:0] data,
                      input logic c, input logic rdy);
    cap_en = cap; cap_ch = ch; cap_data = data; clr = c; out_ready = rdy;
    #1;
    if (!c && rdy && exp_q0.size() != 0) check("pop0", 128'({out_ch0, out_data0}), 128'(exp_q0.pop_front()));
    if (!c && rdy && exp_q1.size() != 0) check("pop1", 128'({out_ch1, out_data1}), 128'(exp_q1.pop_front()));
    if (cap && !c) begin
      if (exp_q0.size() < DEPTH) exp_q0.push_back({ch, data});
      else begin
        ovf_m0 = 1'b1;
        if (drop_m0 != 16'hFFFF) drop_m0 = drop_m0 + 16'd1;
      end
      if (exp_q1.size() == DEPTH) begin
        void'(exp_q1.pop_front());
        ovf_m1 = 1'b1;
        if (drop_m1 != 16'hFFFF) drop_m1 = drop_m1 + 16'd1;
      end
      exp_q1.push_back({ch, data});
    end
    if (cap) dr_m[ch] = data;
    if (c) begin
      exp_q0.delete(); exp_q1.delete();
      ovf_m0 = 1'b0; ovf_m1 = 1'b0; drop_m0 = '0; drop_m1 = '0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic cap);
    reset = 1'b1; cap_en = cap; cap_ch = 2'd3; cap_data = 32'hAAAA_5555; clr = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    exp_q0.delete(); exp_q1.delete();
    ovf_m0 = 1'b0; ovf_m1 = 1'b0; drop_m0 = '0; drop_m1 = '0;
    for (int k = 0; k < 4; k++) dr_m[k] = '0;
    check_status();
    reset = 1'b0; cap_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && (exp_q0.size() != 0 || exp_q1.size() != 0); i++)
      step(1'b0, 2'd0, 32'd0, 1'b0, 1'b1);
    check_status();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b1; cap_en = 1'b0; cap_ch = '0; cap_data = '0; clr = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    do_reset(1'b0);
    check("rst_dr", dr0, 128'd0);

    // Single capture on channel 2, consumer stalled
    step(1'b1, 2'd2, 32'h1234_5678, 1'b0, 1'b0);
    check_status();
    check("c1_dr", 128'(dr0[95:64]), 128'(32'h1234_5678));
    check("c1_count", 128'(count0), 128'd1);
    check("c1_ch", 128'(out_ch0), 128'd2);
    check("c1_data", 128'(out_data0), 128'(32'h1234_5678));
    drain();

    // Overflow: five then six captures on channel 0, consumer stalled
    for (int v = 1; v <= 5; v++) step(1'b1, 2'd0, 32'(v), 1'b0, 1'b0);
    check_status();
    check("m0_count", 128'(count0), 128'd4);
    check("m0_ovf", 128'(ovf0), 128'd1);
    check("m0_drop", 128'(drop0), 128'd1);
    check("m0_dr", 128'(dr0[31:0]), 128'd5);
    step(1'b1, 2'd0, 32'd6, 1'b0, 1'b0);
    check_status();
    check("m1_count", 128'(count1), 128'd4);
    check("m1_drop", 128'(drop1), 128'd2);
    check("m0_head", 128'(out_data0), 128'd1);
    check("m1_head", 128'(out_data1), 128'd3);
    drain();

    // Full FIFO with push and pop in the same cycle is not an overflow
    step(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
    for (int v = 10; v < 14; v++) step(1'b1, 2'd3, 32'(v), 1'b0, 1'b0);
    step(1'b1, 2'd3, 32'd14, 1'b0, 1'b1);
    check_status();
    check("pp_count", 128'(count0), 128'd4);
    check("pp_ovf0", 128'(ovf0), 128'd0);
    check("pp_ovf1", 128'(ovf1), 128'd0);
    drain();

    // clr wins over a same-cycle push, dr still loads
    for (int v = 20; v < 23; v++) step(1'b1, 2'd2, 32'(v), 1'b0, 1'b0);
    step(1'b1, 2'd1, 32'd9, 1'b1, 1'b0);
    check_status();
    check("clr_count", 128'(count0), 128'd0);
    check("clr_ovf", 128'(ovf0), 128'd0);
    check("clr_dr", 128'(dr0[63:32]), 128'd9);

    // Reset mid-stream with a capture pending
    step(1'b1, 2'd0, 32'd30, 1'b0, 1'b0);
    step(1'b1, 2'd1, 32'd31, 1'b0, 1'b0);
    do_reset(1'b1);
    check("rst2_dr", dr0, 128'd0);
    check("rst2_count", 128'(count0), 128'd0);
    check("rst2_valid", 128'(out_valid0), 128'd0);
    check("rst2_drop", 128'(drop0), 128'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
           1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 2) == 0));
      check_status();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
